// File: rtl/ofmap_collector_pkg.sv
// Shared definitions for the ofmap collector: register offsets, STATUS layout,
// ICB response FSM states and the offset decoder.
package ofmap_collector_pkg;

    localparam logic [11:0] RESULT_BASE = 12'h000;
    localparam logic [11:0] STATUS_OFS  = 12'h100;
    localparam logic [11:0] CONTROL_OFS = 12'h104;

    localparam int STATUS_CNT_LSB  = 0;
    localparam int STATUS_CNT_W    = 8;
    localparam int STATUS_DONE_BIT = 8;
    localparam int STATUS_OVF_BIT  = 9;

    typedef enum logic {
        ICB_IDLE = 1'b0,
        ICB_RSP  = 1'b1
    } icb_state_e;

    typedef enum logic [1:0] {
        OFS_RESULT   = 2'd0,
        OFS_STATUS   = 2'd1,
        OFS_CONTROL  = 2'd2,
        OFS_UNMAPPED = 2'd3
    } ofs_e;

    // Word-granular decode; byte lane bits [1:0] do not select anything.
    function automatic ofs_e decode_ofs(input logic [11:0] ofs);
        if (ofs[11:8] == RESULT_BASE[11:8]) return OFS_RESULT;
        if (ofs[11:2] == STATUS_OFS[11:2])  return OFS_STATUS;
        if (ofs[11:2] == CONTROL_OFS[11:2]) return OFS_CONTROL;
        return OFS_UNMAPPED;
    endfunction

endpackage

// File: rtl/ofmap_result_ram.sv
// Result word store: one write port, one read port with a registered output
// that reads the pre-write content when both hit the same word on one edge.
module ofmap_result_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output only moves on a read, so a held ICB response stays stable.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ofmap_collector.sv
// Packs fp16 conv results two per 32-bit word into a result RAM and exposes
// the words plus STATUS/CONTROL over a single-outstanding ICB slave port.
module ofmap_collector
    import ofmap_collector_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dout_valid,
    input  logic [15:0] ofmap_in,
    input  logic        conv_done,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_addr,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic        irq
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(2 * DEPTH_WORDS + 1);
    localparam logic [CW-1:0] CAP = CW'(2 * DEPTH_WORDS);

    icb_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   pack_q, pack_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_ram_q, rsp_ram_d;

    logic          cmd_hs;
    ofs_e          cmd_sel;
    logic          ctrl_clear;
    logic          accept;
    logic [CW-1:0] cnt_acc;
    logic [31:0]   status_word;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_rdata;

    logic          unused_bits;
    assign unused_bits = ^{icb_cmd_wmask, icb_cmd_addr[31:12], icb_cmd_addr[1:0],
                           icb_cmd_wdata[31:1]};

    assign icb_cmd_ready = (state_q == ICB_IDLE) | icb_rsp_ready;
    assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;

    always_comb begin
        cmd_sel = decode_ofs(icb_cmd_addr[11:0]);
        if (cmd_sel == OFS_RESULT && 32'(icb_cmd_addr[7:2]) >= DEPTH_WORDS) begin
            cmd_sel = OFS_UNMAPPED;
        end
    end

    assign ctrl_clear = cmd_hs & ~icb_cmd_read & (cmd_sel == OFS_CONTROL) & icb_cmd_wdata[0];
    assign accept     = dout_valid & (count_q < CAP);
    assign cnt_acc    = count_q + CW'(accept);

    always_comb begin
        status_word = '0;
        status_word[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(count_q);
        status_word[STATUS_DONE_BIT] = done_q;
        status_word[STATUS_OVF_BIT]  = ovf_q;
    end

    // Ingest path: the accept and the frame-end flush share the single write
    // port, which works because at most one of them can produce a write.
    always_comb begin
        count_d   = count_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        pack_d    = pack_q;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (ctrl_clear) begin
            count_d = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            pack_d  = '0;
        end else begin
            if (dout_valid && !accept) begin
                ovf_d = 1'b1;
            end
            if (accept) begin
                count_d = cnt_acc;
                if (!count_q[0]) begin
                    pack_d = ofmap_in;
                end else begin
                    ram_we    = 1'b1;
                    ram_waddr = count_q[1 +: AW];
                    ram_wdata = {ofmap_in, pack_q};
                end
            end
            if (conv_done) begin
                done_d = 1'b1;
                if (cnt_acc[0]) begin
                    ram_we    = 1'b1;
                    ram_waddr = cnt_acc[1 +: AW];
                    ram_wdata = {16'h0000, accept ? ofmap_in : pack_q};
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_ram_d   = rsp_ram_q;
        ram_re      = 1'b0;
        ram_raddr   = icb_cmd_addr[2 +: AW];
        if (state_q == ICB_RSP && icb_rsp_ready) begin
            state_d = ICB_IDLE;
        end
        if (cmd_hs) begin
            state_d     = ICB_RSP;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            rsp_ram_d   = 1'b0;
            unique case (cmd_sel)
                OFS_RESULT: begin
                    if (icb_cmd_read) begin
                        ram_re    = 1'b1;
                        rsp_ram_d = 1'b1;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                OFS_STATUS: begin
                    if (icb_cmd_read) rsp_rdata_d = status_word;
                    else              rsp_err_d   = 1'b1;
                end
                OFS_CONTROL: begin
                    rsp_rdata_d = '0;
                end
                default: begin
                    rsp_err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ICB_IDLE;
            count_q     <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            pack_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_ram_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            pack_q      <= pack_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ram_q   <= rsp_ram_d;
        end
    end

    ofmap_result_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign icb_rsp_valid = (state_q == ICB_RSP);
    assign icb_rsp_rdata = rsp_ram_q ? ram_rdata : rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign irq           = done_q;

endmodule

// File: tb/tb_ofmap_collector.sv
// Self-checking bench for ofmap_collector: directed frames, a register table,
// ICB corner sequences and randomized frames against a sample-list model.
module tb_ofmap_collector;
    import ofmap_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dout_valid = 1'b0;
    logic [15:0] ofmap_in = '0;
    logic        conv_done = 1'b0;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_addr = '0;
    logic [31:0] icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = 4'hF;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b1;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        irq;

    always #5 clk = ~clk;

    ofmap_collector #(.DEPTH_WORDS(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dout_valid    (dout_valid),
        .ofmap_in      (ofmap_in),
        .conv_done     (conv_done),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the list of accepted samples and the words they imply.
    int          m_count;
    bit          m_done, m_ovf;
    logic [15:0] m_samp [128];
    logic [31:0] m_mem  [64];
    bit          m_known[64];

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {22'd0, m_ovf, m_done, 8'(m_count)};
    endfunction

    task automatic m_sample(input logic [15:0] s);
        if (m_count < 128) begin
            m_samp[m_count] = s;
            if (m_count % 2 == 1) begin
                m_mem[m_count / 2]   = {s, m_samp[m_count - 1]};
                m_known[m_count / 2] = 1'b1;
            end
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic m_frame_done();
        m_done = 1'b1;
        if (m_count % 2 == 1) begin
            m_mem[m_count / 2]   = {16'h0000, m_samp[m_count - 1]};
            m_known[m_count / 2] = 1'b1;
        end
    endtask

    task automatic m_clear();
        m_count = 0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic feed(input logic [15:0] s);
        @(negedge clk);
        dout_valid = 1'b1;
        ofmap_in   = s;
        m_sample(s);
        @(posedge clk);
        #1 dout_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        conv_done = 1'b1;
        m_frame_done();
        @(posedge clk);
        #1 conv_done = 1'b0;
    endtask

    task automatic icb(input logic rd, input logic [11:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err);
        int n = 0;
        @(negedge clk);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = {20'h0, addr};
        icb_cmd_wdata = wd;
        while (!icb_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!icb_cmd_ready) begin
            check("cmd_ready_timeout", {31'd0, icb_cmd_ready}, 32'd1);
            icb_cmd_valid = 1'b0;
            rdata = '0;
            err   = 1'b1;
            return;
        end
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0;
        @(negedge clk);
        check("rsp_valid_latency", {31'd0, icb_rsp_valid}, 32'd1);
        rdata = icb_rsp_rdata;
        err   = icb_rsp_err;
        $display("icb %s addr=0x%03h wdata=0x%08h rdata=0x%08h err=%0d",
                 rd ? "rd" : "wr", addr, wd, rdata, err);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        icb(1'b1, addr, 32'd0, r, e);
        check({name, "_rdata"}, r, exp);
        check({name, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic rd_word(input int idx);
        rd_chk($sformatf("word%0d", idx), 12'(idx * 4), m_mem[idx]);
    endtask

    task automatic clear_all();
        logic [31:0] r;
        logic        e;
        icb(1'b0, CONTROL_OFS, 32'h1, r, e);
        check("ctrl_wr_rdata", r, 32'd0);
        check("ctrl_wr_err", {31'd0, e}, 32'd0);
        m_clear();
    endtask

    initial begin
        logic [31:0] r, held;
        logic        e;
        logic [15:0] x, y, z, q;

        m_clear();
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;

        // Reset state, sampled while rst_n is still low.
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
        check("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, icb_rsp_err}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
        rst_n = 1'b1;
        rd_chk("status_after_reset", STATUS_OFS, 32'd0);

        // 120-sample frame then the register table.
        for (int k = 0; k < 120; k++) feed(16'h3C00 + 16'(k));
        pulse_done();
        @(negedge clk);
        check("irq_after_done", {31'd0, irq}, 32'd1);
        vt[0] = '{1'b1, STATUS_OFS,  32'd0, 32'h0000_0178, 1'b0};
        vt[1] = '{1'b1, 12'h000,     32'd0, 32'h3C01_3C00, 1'b0};
        vt[2] = '{1'b1, 12'h0EC,     32'd0, 32'h3C77_3C76, 1'b0};
        vt[3] = '{1'b1, CONTROL_OFS, 32'd0, 32'h0000_0000, 1'b0};
        vt[4] = '{1'b0, 12'h010,     32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vt[5] = '{1'b1, 12'h200,     32'd0, 32'h0000_0000, 1'b1};
        vt[6] = '{1'b1, 12'h010,     32'd0, 32'h3C09_3C08, 1'b0};
        vt[7] = '{1'b1, STATUS_OFS,  32'd0, 32'h0000_0178, 1'b0};
        for (int i = 0; i < 8; i++) begin
            icb(vt[i].rd, vt[i].addr, vt[i].wdata, r, e);
            check($sformatf("vec%0d_rdata", i), r, vt[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
        end

        // Odd-length frame flushes a half word.
        clear_all();
        @(negedge clk);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        feed(16'h1111); feed(16'h2222); feed(16'h3333);
        pulse_done();
        rd_chk("status_odd", STATUS_OFS, 32'h0000_0103);
        rd_chk("word0_odd", 12'h000, 32'h2222_1111);
        rd_chk("word1_flush", 12'h004, 32'h0000_3333);

        // Overflow: 130 samples, only the first 128 stored.
        clear_all();
        for (int k = 0; k < 130; k++) feed(16'($urandom));
        rd_chk("status_ovf", STATUS_OFS, 32'h0000_0280);
        rd_word(63);
        rd_word(0);

        // Sample and conv_done together: accept first, then parity flush.
        clear_all();
        x = 16'hA0A0; y = 16'hB1B1; z = 16'hC2C2; q = 16'hD3D3;
        feed(x);
        @(negedge clk);
        dout_valid = 1'b1; ofmap_in = y; conv_done = 1'b1;
        m_sample(y); m_frame_done();
        @(posedge clk);
        #1 dout_valid = 1'b0; conv_done = 1'b0;
        rd_chk("status_even_done", STATUS_OFS, m_status());
        rd_word(0);
        clear_all();
        @(negedge clk);
        dout_valid = 1'b1; ofmap_in = z; conv_done = 1'b1;
        m_sample(z); m_frame_done();
        @(posedge clk);
        #1 dout_valid = 1'b0; conv_done = 1'b0;
        rd_chk("status_flush_same", STATUS_OFS, 32'h0000_0101);
        rd_chk("word0_flush_same", 12'h000, {16'h0000, z});

        // Read of a word on the edge it is being rewritten returns old data.
        @(negedge clk);
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h0;
        dout_valid = 1'b1; ofmap_in = q;
        held = m_mem[0];
        m_sample(q);
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0; dout_valid = 1'b0;
        @(negedge clk);
        check("rw_collide_valid", {31'd0, icb_rsp_valid}, 32'd1);
        check("rw_collide_rdata", icb_rsp_rdata, held);
        rd_chk("word0_after_collide", 12'h000, {q, z});

        // Response backpressure while ingest keeps running.
        clear_all();
        feed(16'h0001); feed(16'h0002); feed(16'h0003);
        held = m_status();
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = {20'h0, STATUS_OFS};
        @(posedge clk);
        #1 dout_valid = 1'b1; ofmap_in = 16'h00AA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", i), {31'd0, icb_rsp_valid}, 32'd1);
            check($sformatf("bp%0d_rdata", i), icb_rsp_rdata, held);
            check($sformatf("bp%0d_cmd_ready", i), {31'd0, icb_cmd_ready}, 32'd0);
            m_sample(16'h00AA);
            @(posedge clk);
        end
        #1 dout_valid = 1'b0;
        @(negedge clk);
        icb_rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, icb_cmd_ready}, 32'd1);
        check("bp_release_valid", {31'd0, icb_rsp_valid}, 32'd1);
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", {31'd0, icb_rsp_valid}, 32'd1);
        check("bp_next_rdata", icb_rsp_rdata, m_status());

        // CONTROL clear coincident with a sample and conv_done: clear wins.
        clear_all();
        for (int k = 0; k < 129; k++) feed(16'($urandom));
        pulse_done();
        @(negedge clk);
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0;
        icb_cmd_addr = {20'h0, CONTROL_OFS}; icb_cmd_wdata = 32'h1;
        dout_valid = 1'b1; ofmap_in = 16'h7777; conv_done = 1'b1;
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0; dout_valid = 1'b0; conv_done = 1'b0;
        m_clear();
        @(negedge clk);
        check("clr_coinc_err", {31'd0, icb_rsp_err}, 32'd0);
        check("clr_coinc_rdata", icb_rsp_rdata, 32'd0);
        rd_chk("status_clr_coinc", STATUS_OFS, 32'd0);
        check("irq_clr_coinc", {31'd0, irq}, 32'd0);
        rd_word(63);

        // Randomized frames against the model.
        for (int round = 0; round < 4; round++) begin
            int n;
            clear_all();
            n = $urandom_range(0, 140);
            for (int k = 0; k < n; k++) begin
                feed(16'($urandom));
                if ($urandom_range(0, 15) == 0) begin
                    int idx = $urandom_range(0, 63);
                    if (m_known[idx]) rd_word(idx);
                end
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            if ($urandom_range(0, 1) == 1) pulse_done();
            rd_chk($sformatf("rand%0d_status", round), STATUS_OFS, m_status());
            for (int j = 0; j < 6; j++) begin
                int idx = $urandom_range(0, 63);
                if (m_known[idx]) rd_word(idx);
            end
        end

        // Reset in the middle of a held response abandons it.
        @(negedge clk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = {20'h0, STATUS_OFS};
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        m_clear();
        rd_chk("status_after_rst2", STATUS_OFS, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
